alu_serial32: RTL and testbench
===============================

# alu_serial32

Bit-serial 32-bit ALU sequencer that drives a single `alu_1bit` slice one bit per clock, from LSB to MSB. The carry is recirculated through a register. The block sits directly upstream of the 1-bit ALU as its only driver. It presents a word-level start/done interface to the datapath and trades latency (WIDTH cycles) for area.

## Interface
- `WIDTH`, 32, operand/result width; ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `a`  in  WIDTH  operand A; captured on accept.
- `b`  in  WIDTH  operand B; captured on accept.
- `alu_ctr`  in  3  op code; captured on accept.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  held result.
- `c_out`  out  1  final carry (add/sub), else 0.
- `overflow`  out  1  signed overflow (add/sub), else 0.
- `zero`  out  1  `result` == 0.
- `err`  out  1  unsupported `alu_ctr` on last operation.

## Operation
- Op codes:
  - 000 and; 001 or; 010 add; 110 sub; 111 xor.
  - All others are illegal.
- One `alu_1bit` instance, port order (r, c_out, a, b, c_in, alu_ctr).
  - It inverts b internally for 110.
  - The sequencer never inverts b.
- States: IDLE, RUN.
- IDLE → RUN on an edge with `start`=1:
  - Load operand shift registers `sa`, `sb` and `op`.
  - Carry register `cy` ← 1 if op=110, else 0.
  - Bit counter `cnt` ← 0.
- RUN, each edge:
  - Slice inputs are `sa[0]`, `sb[0]`, `cy`, `op`.
  - `sa`, `sb` shift right by one.
  - The slice `r` shifts into the MSB of the accumulator `acc`.
  - `cy` ← slice `c_out`.
  - `cnt`++.
- RUN → IDLE on the edge where `cnt`=WIDTH-1 (last bit). On that same edge:
  - `result` ← final acc (including this bit).
  - `c_out` ← slice carry for add/sub, else 0.
  - `overflow` ← cy (carry into MSB) XOR slice carry, for add/sub only.
  - `err` ← illegal op.
  - `done` ← 1.
- Illegal op: the sequence runs the full WIDTH cycles, then `result`=0, `c_out`=0, `overflow`=0, `err`=1.
- `zero` is combinational from the `result` register.
- `start` while `busy`=1 is ignored; no queueing.
- `result`, `c_out`, `overflow`, `err` hold their values until the next completion. They do not change during RUN.

## Timing
- Reset (async, any time, including mid-RUN):
  - State → IDLE.
  - `busy`=0, `done`=0, `result`=0, `c_out`=0, `overflow`=0, `err`=0, hence `zero`=1.
  - Any operation in flight is discarded.
- Accept edge E0: `busy`=1 from E0 until the edge E_WIDTH.
- Bit i is processed on edge E(i+1).
- `done`=1 for exactly the cycle after E_WIDTH, i.e. WIDTH cycles after accept. `busy`=0 in that same cycle.
- Back-to-back: `start`=1 during the `done` cycle is accepted at the next edge, giving a throughput of one operation per WIDTH+1 cycles.
- Operand inputs need to be stable only at the accept edge.

## Test plan
- Add 0xFFFFFFFF + 0x00000001:
  - Expected: `result`=0, `c_out`=1, `overflow`=0, `zero`=1.
  - `done` exactly 32 cycles after accept.
  - `busy` high for 32 cycles.
- Add 0x7FFFFFFF + 0x00000001: `result`=0x80000000, `overflow`=1, `c_out`=0, `zero`=0.
- Sub 5 − 7: `result`=0xFFFFFFFE, `c_out`=0, `overflow`=0.
- Sub 7 − 5: `result`=2, `c_out`=1.
- Logic ops on a=0xF0F0F0F0, b=0xFF00FF00:
  - and → 0xF000F000; or → 0xFFF0FFF0; xor → 0x0FF00FF0.
  - `c_out`=0 and `overflow`=0 for all three.
- Control behaviour:
  - `start` pulsed at cycle 10 of a RUN is ignored; `result` is unchanged.
  - `start` held during the `done` cycle starts the next operation immediately.
  - Illegal op 011 → `result`=0, `err`=1.
- Reset:
  - `rst_n` low at cycle 15 of a RUN: all outputs go to their reset values immediately, with no `done`.
  - A new add after release completes correctly.

Source files
------------

// File: rtl/alu_serial32.sv
// Bit-serial ALU sequencer: feeds one alu_1bit slice LSB-first, one bit per clock, carry recirculated.
// Latency: WIDTH cycles from accept to the done pulse; one operation per WIDTH+1 cycles back-to-back.
// Backpressure: start is sampled only while idle; a start seen while busy is dropped, never queued.
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_start, i_a, i_b, i_alu_ctr  request and operands, captured on the accept edge
//   o_busy, o_done             in-progress flag, one-cycle completion pulse
//   o_result, o_c_out, o_overflow, o_zero, o_err  held results of the last operation

module alu_1bit (
    output logic       o_r,
    output logic       o_c_out,
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_c_in,
    input  logic [2:0] i_alu_ctr
);
    logic w_b;
    logic w_sum;
    logic w_carry;

    // Subtract is add with b inverted; the +1 comes in through the carry input.
    assign w_b     = (i_alu_ctr == 3'b110) ? ~i_b : i_b;
    assign w_sum   = i_a ^ w_b ^ i_c_in;
    assign w_carry = (i_a & w_b) | (i_a & i_c_in) | (w_b & i_c_in);

    always_comb begin
        o_r     = 1'b0;
        o_c_out = 1'b0;
        case (i_alu_ctr)
            3'b000: o_r = i_a & i_b;
            3'b001: o_r = i_a | i_b;
            3'b010,
            3'b110: begin
                o_r     = w_sum;
                o_c_out = w_carry;
            end
            3'b111: o_r = i_a ^ i_b;
            default: begin
                o_r     = 1'b0;
                o_c_out = 1'b0;
            end
        endcase
    end
endmodule

module alu_serial32 #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_alu_ctr,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_c_out,
    output logic             o_overflow,
    output logic             o_zero,
    output logic             o_err
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic             r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_acc;
    logic [2:0]       r_op;
    logic             r_cy;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_c_out;
    logic             r_overflow;
    logic             r_err;

    logic             w_r;
    logic             w_cout;
    logic             w_last;
    logic             w_legal;
    logic             w_arith;
    logic [WIDTH-1:0] w_acc_next;

    alu_1bit u_slice (
        .o_r       (w_r),
        .o_c_out   (w_cout),
        .i_a       (r_sa[0]),
        .i_b       (r_sb[0]),
        .i_c_in    (r_cy),
        .i_alu_ctr (r_op)
    );

    assign w_last  = (r_cnt == CW'(WIDTH - 1));
    assign w_arith = (r_op == 3'b010) || (r_op == 3'b110);
    assign w_legal = w_arith || (r_op == 3'b000) || (r_op == 3'b001) || (r_op == 3'b111);

    // Result bits arrive LSB first; each new bit enters at the MSB so that after
    // WIDTH shifts the first bit has reached position 0.
    assign w_acc_next = WIDTH'({w_r, r_acc} >> 1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_sa       <= '0;
            r_sb       <= '0;
            r_acc      <= '0;
            r_op       <= 3'b000;
            r_cy       <= 1'b0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_RUN;
                        r_sa    <= i_a;
                        r_sb    <= i_b;
                        r_op    <= i_alu_ctr;
                        r_cy    <= (i_alu_ctr == 3'b110);
                        r_cnt   <= '0;
                        r_acc   <= '0;
                    end
                end
                S_RUN: begin
                    r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
                    r_acc <= w_acc_next;
                    r_cy  <= w_cout;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state    <= S_IDLE;
                        r_done     <= 1'b1;
                        r_result   <= w_legal ? w_acc_next : '0;
                        r_c_out    <= w_arith & w_cout;
                        // r_cy here is the carry into the MSB.
                        r_overflow <= w_arith & (r_cy ^ w_cout);
                        r_err      <= ~w_legal;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy     = (r_state == S_RUN);
    assign o_done     = r_done;
    assign o_result   = r_result;
    assign o_c_out    = r_c_out;
    assign o_overflow = r_overflow;
    assign o_err      = r_err;
    assign o_zero     = (r_result == '0);
endmodule

// File: tb/tb_alu_serial32.sv
module tb_alu_serial32;
    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [2:0]  i_alu_ctr;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;
    logic        o_c_out;
    logic        o_overflow;
    logic        o_zero;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    alu_serial32 #(.WIDTH(32)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_alu_ctr  (i_alu_ctr),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result),
        .o_c_out    (o_c_out),
        .o_overflow (o_overflow),
        .o_zero     (o_zero),
        .o_err      (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Drive a request at the falling edge, let it be accepted at the next
    // rising edge, then scramble the operand inputs.
    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        @(negedge i_clk);
        i_start = 1'b1; i_a = a; i_b = b; i_alu_ctr = op;
        @(posedge i_clk);
        #1;
        i_start = 1'b0; i_a = 32'hDEAD_BEEF; i_b = 32'h1234_5678; i_alu_ctr = 3'b101;
    endtask

    // Edges until done is seen (-1 when it never comes within the budget).
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge i_clk);
            #1;
            if (o_done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          output int lat, output int busy_cnt);
        accept(a, b, op);
        busy_cnt = o_busy ? 1 : 0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge i_clk);
            #1;
            if (o_done) begin
                lat = k;
                break;
            end
            if (o_busy) busy_cnt++;
        end
    endtask

    task automatic test_reset;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_done); end
        checks++; if (o_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", o_result); end
        checks++; if ({o_c_out, o_overflow, o_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {o_c_out, o_overflow, o_err}); end
        checks++; if (o_zero !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", o_zero); end
    endtask

    task automatic test_add;
        int lat, bc;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b010, lat, bc);
        checks++; if (lat !== 32) begin errors++; $display("FAIL add_latency got=%0d exp=32", lat); end
        checks++; if (bc !== 32) begin errors++; $display("FAIL add_busy_cycles got=%0d exp=32", bc); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL add_busy_in_done got=%b exp=0", o_busy); end
        checks++; if (o_result !== 32'h0) begin errors++; $display("FAIL add_wrap_result got=%h exp=0", o_result); end
        checks++; if ({o_c_out, o_overflow, o_zero, o_err} !== 4'b1010) begin errors++; $display("FAIL add_wrap_flags got=%b exp=1010", {o_c_out, o_overflow, o_zero, o_err}); end
        @(posedge i_clk); #1;
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got=%b exp=0", o_done); end
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 3'b010, lat, bc);
        checks++; if (o_result !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_result got=%h exp=80000000", o_result); end
        checks++; if ({o_c_out, o_overflow, o_zero} !== 3'b010) begin errors++; $display("FAIL add_ovf_flags got=%b exp=010", {o_c_out, o_overflow, o_zero}); end
    endtask

    task automatic test_sub;
        int lat, bc;
        run_op(32'd5, 32'd7, 3'b110, lat, bc);
        checks++; if (o_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_5_7_result got=%h exp=fffffffe", o_result); end
        checks++; if ({o_c_out, o_overflow} !== 2'b00) begin errors++; $display("FAIL sub_5_7_flags got=%b exp=00", {o_c_out, o_overflow}); end
        run_op(32'd7, 32'd5, 3'b110, lat, bc);
        checks++; if (o_result !== 32'd2) begin errors++; $display("FAIL sub_7_5_result got=%h exp=2", o_result); end
        checks++; if ({o_c_out, o_overflow} !== 2'b10) begin errors++; $display("FAIL sub_7_5_flags got=%b exp=10", {o_c_out, o_overflow}); end
    endtask

    task automatic test_logic;
        int lat, bc;
        logic [2:0]  ops [3] = '{3'b000, 3'b001, 3'b111};
        logic [31:0] exps[3] = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0};
        for (int i = 0; i < 3; i++) begin
            run_op(32'hF0F0_F0F0, 32'hFF00_FF00, ops[i], lat, bc);
            checks++; if (o_result !== exps[i]) begin errors++; $display("FAIL logic_op%0d_result got=%h exp=%h", i, o_result, exps[i]); end
            checks++; if ({o_c_out, o_overflow, o_err} !== 3'b000) begin errors++; $display("FAIL logic_op%0d_flags got=%b exp=000", i, {o_c_out, o_overflow, o_err}); end
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        accept(32'd1, 32'd2, 3'b010);
        repeat (9) @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b1; i_a = 32'd100; i_b = 32'd100; i_alu_ctr = 3'b111;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        checks++; if (o_result !== 32'h0FF0_0FF0) begin errors++; $display("FAIL result_held_in_run got=%h exp=0ff00ff0", o_result); end
        wait_done(lat);
        checks++; if (lat !== 22) begin errors++; $display("FAIL ignore_latency got=%0d exp=22", lat); end
        checks++; if (o_result !== 32'd3) begin errors++; $display("FAIL ignore_result got=%h exp=3", o_result); end
        @(posedge i_clk); #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart got=%b exp=0", o_busy); end
    endtask

    task automatic test_back_to_back;
        int lat;
        accept(32'd10, 32'd20, 3'b010);
        wait_done(lat);
        // Request the next op during the done cycle.
        i_start = 1'b1; i_a = 32'd100; i_b = 32'd1; i_alu_ctr = 3'b110;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", o_busy); end
        checks++; if (o_result !== 32'd30) begin errors++; $display("FAIL b2b_first_result got=%h exp=1e", o_result); end
        wait_done(lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_latency got=%0d exp=32", lat); end
        checks++; if (o_result !== 32'd99) begin errors++; $display("FAIL b2b_second_result got=%h exp=63", o_result); end
    endtask

    task automatic test_illegal;
        int lat, bc;
        run_op(32'h1234_5678, 32'h1111_1111, 3'b011, lat, bc);
        checks++; if (lat !== 32) begin errors++; $display("FAIL illegal_latency got=%0d exp=32", lat); end
        checks++; if ({o_result, o_c_out, o_overflow, o_err, o_zero} !== {32'h0, 4'b0011}) begin errors++; $display("FAIL illegal_outputs got=%h/%b exp=0/0011", o_result, {o_c_out, o_overflow, o_err, o_zero}); end
        run_op(32'd1, 32'd1, 3'b010, lat, bc);
        checks++; if ({o_result, o_err} !== {32'd2, 1'b0}) begin errors++; $display("FAIL err_clear got=%h/%b exp=2/0", o_result, o_err); end
    endtask

    task automatic test_reset_mid;
        int lat, bc;
        bit  seen;
        run_op(32'd7, 32'd5, 3'b110, lat, bc);
        accept(32'd1, 32'd1, 3'b010);
        repeat (14) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++; if ({o_busy, o_done, o_c_out, o_overflow, o_err, o_zero} !== 6'b000001) begin errors++; $display("FAIL midrun_reset_flags got=%b exp=000001", {o_busy, o_done, o_c_out, o_overflow, o_err, o_zero}); end
        checks++; if (o_result !== 32'h0) begin errors++; $display("FAIL midrun_reset_result got=%h exp=0", o_result); end
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge i_clk); #1;
            if (o_done || o_busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrun_discard got=%b exp=0", seen); end
        run_op(32'd3, 32'd4, 3'b010, lat, bc);
        checks++; if (lat !== 32) begin errors++; $display("FAIL post_reset_latency got=%0d exp=32", lat); end
        checks++; if (o_result !== 32'd7) begin errors++; $display("FAIL post_reset_result got=%h exp=7", o_result); end
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_a = '0; i_b = '0; i_alu_ctr = 3'b000;
        repeat (3) @(posedge i_clk);
        #1;
        test_reset;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        test_add;
        test_sub;
        test_logic;
        test_ignore_start;
        test_back_to_back;
        test_illegal;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
